hawk_axi_wr_arbiter: RTL
========================

// Module: hawk_axi_wr_arbiter
// PURPOSE
// Shares the single AXI write port toward the HACD memory side among NUM_REQ write managers
// (req0 = page writer, req1 = cmpdcmp write manager, req2 = zspage migrate/metadata writer).
// Round-robin grant, held for one complete AW+W+B transaction, or for a lock window of up to MAX_LOCK transactions.
// Owner's AW/W/B signals are muxed combinationally onto the master port; all other requesters see ready=0.
// PARAMETERS
// NUM_REQ   3    number of requesters (2..8)
// ADDR_W    64   AXI address width
// DATA_W    512  AXI data width (one 64B cache line per transaction; single-beat only)
// MAX_LOCK  64   max back-to-back transactions one owner keeps under req_lock
// PORTS
// clk_i        in   1               clock
// rst_ni       in   1               async active-low reset
// req_awvalid  in   NUM_REQ         per-requester AW valid
// req_awaddr   in   NUM_REQ*ADDR_W  per-requester AW address, slice i = [i*ADDR_W +: ADDR_W]
// req_awready  out  NUM_REQ         AW ready back to requester
// req_wvalid   in   NUM_REQ         per-requester W valid
// req_wdata    in   NUM_REQ*DATA_W  per-requester W data
// req_wstrb    in   NUM_REQ*DATA_W/8  per-requester W strobe
// req_wready   out  NUM_REQ         W ready back to requester
// req_lock     in   NUM_REQ         keep grant after current B (multi-line page transfers)
// req_bvalid   out  NUM_REQ         B response valid routed to owner
// req_bresp    out  2               B response (valid only with req_bvalid)
// m_awvalid/m_awaddr/m_awready     out/out/in  1/ADDR_W/1  master AW channel
// m_wvalid/m_wdata/m_wstrb/m_wready out/out/out/in 1/DATA_W/DATA_W/8/1 master W channel
// m_bvalid/m_bresp/m_bready        in/in/out   1/2/1  master B channel
// grant_o      out  NUM_REQ         one-hot current owner (0 when IDLE)
// err_o        out  1               sticky: a B with bresp!=OKAY was seen
// err_id_o     out  $clog2(NUM_REQ) owner of first erroring B
// BEHAVIOUR
// Reset: state=IDLE, grant_o=0, rr_ptr=NUM_REQ-1, lock_cnt=0, err_o=0, err_id_o=0; all m_*valid, m_bready, req_*ready, req_bvalid=0.
// States: IDLE -> XFER -> RESP -> (XFER on lock-retain | IDLE).
// IDLE: candidate = req_awvalid|req_wvalid; first set bit scanning rr_ptr+1 upward with wrap.
//   Winner registered -> XFER next cycle, i.e. 1-cycle arbitration latency; rr_ptr<=winner, aw_done=w_done=0.
// XFER: m_aw*/m_w* = owner's signals; req_awready[own]=m_awready, req_wready[own]=m_wready.
//   AW and W are independent; either order or the same cycle. aw_done/w_done set on their handshake.
//   When both are done (including simultaneous final handshakes) -> RESP. No second AW accepted before B.
// RESP: m_bready=1; req_bvalid[own]=m_bvalid; req_bresp=m_bresp. On m_bvalid:
//   if bresp!=0 and !err_o: err_o<=1, err_id_o<=owner.
//   if req_lock[own] && lock_cnt<MAX_LOCK-1: lock_cnt++, clear done flags -> XFER, same owner.
//   else lock_cnt<=0, grant_o<=0 -> IDLE; rr rotation starts after this owner.
// Lock sampled only at B; dropping it mid-transaction has no effect until then.
// MAX_LOCK=64 lets a full 4KB decompressed page (64 lines) go in one window; the 65th request re-arbitrates.
// Owner deasserting valid before handshake is an AXI violation: arbiter keeps grant, no timeout.
// Non-owner valids are ignored; their readies are 0 (no combinational path from other requesters).
// Reset mid-transaction: immediate return to reset values; downstream shares rst_ni, so no drain.
// err_o cleared only by reset.
// STRUCTURE
// hacd_pkg: arb_state_e {IDLE,XFER,RESP}, AXI_RESP_OKAY=2'b00, debug_wr_arb_t {state, grant, lock_cnt} for debug bus.
// Sub-module hawk_rr_pick: combinational round-robin priority picker (req vector + ptr -> one-hot + index).
// Muxing and FSM live in the top; lock_cnt width $clog2(MAX_LOCK).
// TESTING
// 1 Reset with req_awvalid=3'b111 held -> grant_o=0, no m_awvalid during reset; 1 cycle after release grant_o=3'b001.
// 2 All three request continuously, no lock, m_*ready=1, B 2 cycles later -> grants 001,010,100,001; awaddr of each forwarded intact.
// 3 req1 W valid 3 cycles before AW, addr 0x1000, data {32{16'h1234}} -> single m_aw+m_w; RESP only after both; B routed to req_bvalid[1] only.
// 4 req1 req_lock=1 for 70 lines, req0 also pending -> req1 owns 64 consecutive B's; then req0 granted; req1 resumes after.
// 5 m_bresp=2'b10 on req2's transaction -> err_o=1, err_id_o=2; later error on req0 leaves err_id_o=2.
// 6 Assert rst_ni low while in XFER with AW done, W pending -> all outputs at reset values same cycle; clean re-arbitration after.

Source files
------------

// File: rtl/hacd_pkg.sv
// rtl/hacd_pkg.sv - shared types and constants for the HACD write-port arbiter
package hacd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } arb_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Sized for the largest supported configuration (8 requesters, 64-deep lock window).
    typedef struct packed {
        arb_state_e state;
        logic [7:0] grant;
        logic [6:0] lock_cnt;
    } debug_wr_arb_t;

endpackage

// File: rtl/hawk_rr_pick.sv
// rtl/hawk_rr_pick.sv - combinational round-robin picker: first set bit after ptr, with wrap
module hawk_rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/hawk_axi_wr_arbiter.sv
// rtl/hawk_axi_wr_arbiter.sv - round-robin arbiter sharing one single-beat AXI write port
module hawk_axi_wr_arbiter
    import hacd_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 512,
    parameter int MAX_LOCK = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          req_awvalid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_awaddr,
    output logic [NUM_REQ-1:0]          req_awready,
    input  logic [NUM_REQ-1:0]          req_wvalid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]          req_wready,
    input  logic [NUM_REQ-1:0]          req_lock,
    output logic [NUM_REQ-1:0]          req_bvalid,
    output logic [1:0]                  req_bresp,
    output logic                        m_awvalid,
    output logic [ADDR_W-1:0]           m_awaddr,
    input  logic                        m_awready,
    output logic                        m_wvalid,
    output logic [DATA_W-1:0]           m_wdata,
    output logic [DATA_W/8-1:0]         m_wstrb,
    input  logic                        m_wready,
    input  logic                        m_bvalid,
    input  logic [1:0]                  m_bresp,
    output logic                        m_bready,
    output logic [NUM_REQ-1:0]          grant_o,
    output logic                        err_o,
    output logic [$clog2(NUM_REQ)-1:0]  err_id_o
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int LOCK_W = $clog2(MAX_LOCK);
    localparam int STRB_W = DATA_W / 8;

    arb_state_e        state;
    logic [IDX_W-1:0]  own;
    logic [IDX_W-1:0]  rr_ptr;
    logic [LOCK_W-1:0] lock_cnt;
    logic              aw_done;
    logic              w_done;

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               in_xfer;
    logic               in_resp;
    logic               aw_hs;
    logic               w_hs;

    assign cand = req_awvalid | req_wvalid;

    hawk_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (cand),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign in_xfer = (state == XFER);
    assign in_resp = (state == RESP);

    // Each channel is closed once it has handshaked, so a second AW cannot slip through before B.
    assign m_awvalid = in_xfer && !aw_done && req_awvalid[own];
    assign m_awaddr  = req_awaddr[own*ADDR_W +: ADDR_W];
    assign m_wvalid  = in_xfer && !w_done && req_wvalid[own];
    assign m_wdata   = req_wdata[own*DATA_W +: DATA_W];
    assign m_wstrb   = req_wstrb[own*STRB_W +: STRB_W];
    assign m_bready  = in_resp;
    assign req_bresp = (in_resp && m_bvalid) ? m_bresp : 2'b00;

    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;

    always_comb begin
        req_awready = '0;
        req_wready  = '0;
        req_bvalid  = '0;
        if (in_xfer) begin
            req_awready[own] = m_awready && !aw_done;
            req_wready[own]  = m_wready && !w_done;
        end
        if (in_resp) begin
            req_bvalid[own] = m_bvalid;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            own      <= '0;
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
            lock_cnt <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            grant_o  <= '0;
            err_o    <= 1'b0;
            err_id_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state   <= XFER;
                        grant_o <= pick_gnt;
                        own     <= pick_idx;
                        rr_ptr  <= pick_idx;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                XFER: begin
                    aw_done <= aw_done | aw_hs;
                    w_done  <= w_done | w_hs;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (m_bvalid) begin
                        if (m_bresp != AXI_RESP_OKAY && !err_o) begin
                            err_o    <= 1'b1;
                            err_id_o <= own;
                        end
                        // Lock is only looked at here, when the transaction's B arrives.
                        if (req_lock[own] && lock_cnt < LOCK_W'(MAX_LOCK - 1)) begin
                            lock_cnt <= lock_cnt + LOCK_W'(1);
                            aw_done  <= 1'b0;
                            w_done   <= 1'b0;
                            state    <= XFER;
                        end else begin
                            lock_cnt <= '0;
                            grant_o  <= '0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
